// File: rtl/imba_menu_pkg.sv
// Shared definitions for the imba menu: page codes, per-page item counts,
// waveform selection codes and the power-on values of the feature enables.
package imba_menu_pkg;

    // Width of the debounce stable-high counter.
    localparam int DB_CNT_W = 20;

    // Menu pages; the encoding is what the drawing block sees on menu_state.
    typedef enum logic [1:0] {
        PAGE_MAIN = 2'b00,
        PAGE_WAVE = 2'b01,
        PAGE_DISP = 2'b10,
        PAGE_ANA  = 2'b11
    } page_e;

    // Number of selectable items on each page (Back included where present).
    localparam logic [2:0] ITEMS_MAIN = 3'd3;
    localparam logic [2:0] ITEMS_WAVE = 3'd5;
    localparam logic [2:0] ITEMS_DISP = 3'd4;
    localparam logic [2:0] ITEMS_ANA  = 3'd3;

    // Waveform styles; item index on the waveform page maps directly onto these.
    typedef enum logic [1:0] {
        WAVE_DEFAULT = 2'b00,
        WAVE_PULSAR  = 2'b01,
        WAVE_BLOCKS  = 2'b10,
        WAVE_NONE    = 2'b11
    } wave_e;

    // Feature enables after reset.
    localparam logic RST_AXIS_EN  = 1'b1;
    localparam logic RST_GRID_EN  = 1'b0;
    localparam logic RST_TICKS_EN = 1'b1;
    localparam logic RST_FFT_EN   = 1'b0;
    localparam logic RST_AMP_EN   = 1'b0;

    // Index of the last item on a page (the Back item on sub-pages).
    function automatic logic [2:0] last_item(input page_e page);
        logic [2:0] last;
        case (page)
            PAGE_MAIN: last = ITEMS_MAIN - 3'd1;
            PAGE_WAVE: last = ITEMS_WAVE - 3'd1;
            PAGE_DISP: last = ITEMS_DISP - 3'd1;
            default:   last = ITEMS_ANA - 3'd1;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, stable-high counter and a
// single-cycle pulse per press. A press only counts once the button has been
// seen low since the previous pulse (or since reset), so a button held through
// reset or held after its pulse never produces another one.
module button_debounce
    import imba_menu_pkg::*;
#(
    parameter logic [DB_CNT_W-1:0] DEBOUNCE_CYCLES = 20'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                armed_q, armed_d;
    logic [DB_CNT_W-1:0] count_q, count_d;
    logic                pulse_q, pulse_d;

    // Synchroniser resets to "high" so a button held across reset must be
    // observed released before it can arm again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            armed_q <= 1'b0;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            armed_q <= armed_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    // Count consecutive high samples; fire once when the count completes.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        armed_d = armed_q;
        count_d = count_q;
        pulse_d = 1'b0;
        if (!sync2_q) begin
            count_d = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (count_q == DEBOUNCE_CYCLES - 1'b1) begin
                pulse_d = 1'b1;
                armed_d = 1'b0;
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/imba_menu_controller.sv
// Menu navigation: clap opens/closes the menu, debounced up/down/select move
// the cursor, change pages and update the persistent display/wave settings.
module imba_menu_controller
    import imba_menu_pkg::*;
#(
    parameter logic [DB_CNT_W-1:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [11:0]         ROW0_Y          = 12'd864,
    parameter logic [11:0]         ROW_PITCH       = 12'd16
) (
    input  logic        CLK_VGA,
    input  logic        RESET,
    input  logic        clap_pulse,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_select,
    output logic        Menu_Clap,
    output logic [1:0]  menu_state,
    output logic [2:0]  cursor,
    output logic [11:0] cursor_y,
    output logic [1:0]  wave_sel,
    output logic        axis_en,
    output logic        grid_en,
    output logic        ticks_en,
    output logic        fft_en,
    output logic        amp_en
);

    logic up_p, down_p, sel_p;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(CLK_VGA), .rst(RESET), .btn_raw(btn_up), .pulse(up_p)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(CLK_VGA), .rst(RESET), .btn_raw(btn_down), .pulse(down_p)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (
        .clk(CLK_VGA), .rst(RESET), .btn_raw(btn_select), .pulse(sel_p)
    );

    logic        open_q, open_d;
    page_e       page_q, page_d;
    logic [2:0]  cursor_q, cursor_d;
    logic [11:0] cursor_y_q, cursor_y_d;
    wave_e       wave_q, wave_d;
    logic        axis_q, axis_d;
    logic        grid_q, grid_d;
    logic        ticks_q, ticks_d;
    logic        fft_q, fft_d;
    logic        amp_q, amp_d;
    logic [2:0]  last;

    // State and settings registers.
    always_ff @(posedge CLK_VGA) begin
        if (RESET) begin
            open_q     <= 1'b0;
            page_q     <= PAGE_MAIN;
            cursor_q   <= 3'd0;
            cursor_y_q <= ROW0_Y;
            wave_q     <= WAVE_DEFAULT;
            axis_q     <= RST_AXIS_EN;
            grid_q     <= RST_GRID_EN;
            ticks_q    <= RST_TICKS_EN;
            fft_q      <= RST_FFT_EN;
            amp_q      <= RST_AMP_EN;
        end else begin
            open_q     <= open_d;
            page_q     <= page_d;
            cursor_q   <= cursor_d;
            cursor_y_q <= cursor_y_d;
            wave_q     <= wave_d;
            axis_q     <= axis_d;
            grid_q     <= grid_d;
            ticks_q    <= ticks_d;
            fft_q      <= fft_d;
            amp_q      <= amp_d;
        end
    end

    // Next state: clap beats select beats up/down; lower-priority pulses are dropped.
    always_comb begin
        open_d   = open_q;
        page_d   = page_q;
        cursor_d = cursor_q;
        wave_d   = wave_q;
        axis_d   = axis_q;
        grid_d   = grid_q;
        ticks_d  = ticks_q;
        fft_d    = fft_q;
        amp_d    = amp_q;
        last     = last_item(page_q);

        if (clap_pulse) begin
            open_d = !open_q;
            if (!open_q) begin
                page_d   = PAGE_MAIN;
                cursor_d = 3'd0;
            end
        end else if (open_q) begin
            if (sel_p) begin
                case (page_q)
                    PAGE_MAIN: begin
                        page_d   = page_e'(cursor_q[1:0] + 2'd1);
                        cursor_d = 3'd0;
                    end
                    PAGE_WAVE: begin
                        if (cursor_q == last) begin
                            page_d   = PAGE_MAIN;
                            cursor_d = 3'd0;
                        end else begin
                            wave_d = wave_e'(cursor_q[1:0]);
                        end
                    end
                    PAGE_DISP: begin
                        if (cursor_q == last) begin
                            page_d   = PAGE_MAIN;
                            cursor_d = 3'd1;
                        end else begin
                            case (cursor_q)
                                3'd0:    axis_d  = !axis_q;
                                3'd1:    grid_d  = !grid_q;
                                default: ticks_d = !ticks_q;
                            endcase
                        end
                    end
                    default: begin
                        if (cursor_q == last) begin
                            page_d   = PAGE_MAIN;
                            cursor_d = 3'd2;
                        end else if (cursor_q == 3'd0) begin
                            fft_d = !fft_q;
                        end else begin
                            amp_d = !amp_q;
                        end
                    end
                endcase
            end else if (up_p && !down_p) begin
                cursor_d = (cursor_q == 3'd0) ? last : cursor_q - 3'd1;
            end else if (down_p && !up_p) begin
                cursor_d = (cursor_q == last) ? 3'd0 : cursor_q + 3'd1;
            end
        end

        cursor_y_d = ROW0_Y + ROW_PITCH * {9'd0, cursor_d};
    end

    assign Menu_Clap  = open_q;
    assign menu_state = page_q;
    assign cursor     = cursor_q;
    assign cursor_y   = cursor_y_q;
    assign wave_sel   = wave_q;
    assign axis_en    = axis_q;
    assign grid_en    = grid_q;
    assign ticks_en   = ticks_q;
    assign fft_en     = fft_q;
    assign amp_en     = amp_q;

endmodule

// File: tb/tb_imba_menu_controller.sv
// Bench for imba_menu_controller: directed scenarios plus random button/clap
// traffic, compared against a page/item level model of the menu.
module tb_imba_menu_controller;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clap_pulse = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_select = 1'b0;
    logic        menu_clap;
    logic [1:0]  menu_state;
    logic [2:0]  cursor;
    logic [11:0] cursor_y;
    logic [1:0]  wave_sel;
    logic        axis_en, grid_en, ticks_en, fft_en, amp_en;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the menu in terms of pages and items.
    int m_open, m_page, m_cursor, m_wave;
    int m_axis, m_grid, m_ticks, m_fft, m_amp;
    int items [4] = '{3, 5, 4, 3};

    imba_menu_controller #(
        .DEBOUNCE_CYCLES(20'd4),
        .ROW0_Y(12'd864),
        .ROW_PITCH(12'd16)
    ) dut (
        .CLK_VGA(clk), .RESET(rst), .clap_pulse(clap_pulse),
        .btn_up(btn_up), .btn_down(btn_down), .btn_select(btn_select),
        .Menu_Clap(menu_clap), .menu_state(menu_state), .cursor(cursor),
        .cursor_y(cursor_y), .wave_sel(wave_sel), .axis_en(axis_en),
        .grid_en(grid_en), .ticks_en(ticks_en), .fft_en(fft_en), .amp_en(amp_en)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_page = 0; m_cursor = 0; m_wave = 0;
        m_axis = 1; m_grid = 0; m_ticks = 1; m_fft = 0; m_amp = 0;
    endtask

    task automatic model_clap();
        if (m_open == 0) begin
            m_open = 1; m_page = 0; m_cursor = 0;
        end else begin
            m_open = 0;
        end
    endtask

    task automatic model_select();
        if (m_page == 0) begin
            m_page = m_cursor + 1;
            m_cursor = 0;
        end else if (m_cursor == items[m_page] - 1) begin
            m_cursor = m_page - 1;
            m_page = 0;
        end else if (m_page == 1) begin
            m_wave = m_cursor;
        end else if (m_page == 2) begin
            if (m_cursor == 0) m_axis = 1 - m_axis;
            else if (m_cursor == 1) m_grid = 1 - m_grid;
            else m_ticks = 1 - m_ticks;
        end else begin
            if (m_cursor == 0) m_fft = 1 - m_fft;
            else m_amp = 1 - m_amp;
        end
    endtask

    task automatic model_buttons(input bit u, input bit d, input bit s);
        if (m_open == 0) return;
        if (s) model_select();
        else if (u && !d) m_cursor = (m_cursor + items[m_page] - 1) % items[m_page];
        else if (d && !u) m_cursor = (m_cursor + 1) % items[m_page];
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".menu_clap"}, 32'(menu_clap), 32'(m_open));
        check_eq({tag, ".menu_state"}, 32'(menu_state), 32'(m_page));
        check_eq({tag, ".cursor"}, 32'(cursor), 32'(m_cursor));
        check_eq({tag, ".cursor_y"}, 32'(cursor_y), 32'(864 + 16 * m_cursor));
        check_eq({tag, ".wave_sel"}, 32'(wave_sel), 32'(m_wave));
        check_eq({tag, ".axis"}, 32'(axis_en), 32'(m_axis));
        check_eq({tag, ".grid"}, 32'(grid_en), 32'(m_grid));
        check_eq({tag, ".ticks"}, 32'(ticks_en), 32'(m_ticks));
        check_eq({tag, ".fft"}, 32'(fft_en), 32'(m_fft));
        check_eq({tag, ".amp"}, 32'(amp_en), 32'(m_amp));
    endtask

    // Driver tasks: inputs change on the falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic clap();
        @(negedge clk);
        clap_pulse = 1'b1;
        @(negedge clk);
        clap_pulse = 1'b0;
        model_clap();
    endtask

    // Hold the given buttons for `hold` rising edges, release, let things settle.
    task automatic press(input bit u, input bit d, input bit s, input int hold);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_select = s;
        idle(hold);
        btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
        idle(DB);
        if (hold >= DB) model_buttons(u, d, s);
    endtask

    task automatic up();   press(1'b1, 1'b0, 1'b0, DB + 1); endtask
    task automatic down(); press(1'b0, 1'b1, 1'b0, DB + 1); endtask
    task automatic sel();  press(1'b0, 1'b0, 1'b1, DB + 1); endtask

    // Clap lands in the same cycle as the select pulse (two syncs plus DB counts later).
    task automatic clap_with_select();
        @(negedge clk);
        btn_select = 1'b1;
        idle(DB + 2);
        clap_pulse = 1'b1;
        @(negedge clk);
        clap_pulse = 1'b0;
        idle(2);
        btn_select = 1'b0;
        idle(DB);
        model_clap();
    endtask

    initial begin
        model_reset();
        idle(3);
        rst = 1'b0;
        check_all("reset");

        clap();
        check_all("open");

        press(1'b0, 1'b1, 1'b0, DB - 1);
        check_all("short_down");
        press(1'b0, 1'b1, 1'b0, DB + 2);
        check_all("long_down");
        press(1'b0, 1'b1, 1'b0, DB);
        check_all("exact_down");
        up(); up();
        check_eq("main_back_to0", 32'(cursor), 32'd0);

        // Analysis page round trip.
        up();
        check_all("up_wrap");
        sel();
        check_all("enter_ana");
        sel();
        check_all("fft_on");
        down(); down(); sel();
        check_all("ana_back");

        // Waveform page.
        up(); up(); sel();
        check_all("enter_wave");
        down(); down(); sel();
        check_all("wave_blocks");
        down(); down(); sel();
        check_all("wave_back");

        // Display page: grid toggles, then clap wins over select.
        down(); sel(); down();
        sel();
        check_all("grid_on");
        sel();
        check_all("grid_off");
        clap_with_select();
        check_all("clap_over_select");

        // Menu closed: presses are ignored.
        for (int i = 0; i < 10; i++) down();
        check_all("closed_downs");

        // Reset while a button is held: no pulse until released and re-pressed.
        clap();
        @(negedge clk);
        btn_down = 1'b1;
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        model_reset();
        check_all("reset_held");
        clap();
        idle(3 * DB);
        check_all("held_after_reset");
        btn_down = 1'b0;
        idle(DB);
        down();
        check_all("repress_after_reset");

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0: clap();
                1: press(1'b1, 1'b0, 1'b0, $urandom_range(DB, DB + 3));
                2: press(1'b0, 1'b1, 1'b0, $urandom_range(DB, DB + 3));
                3: press(1'b0, 1'b0, 1'b1, $urandom_range(DB, DB + 3));
                4: press(1'b1, 1'b1, 1'b0, $urandom_range(DB, DB + 3));
                5: press(1'b0, 1'b0, 1'b1, $urandom_range(1, DB - 1));
                default: if (m_open == 0) clap(); else press(1'b0, 1'b1, 1'b0, DB + 1);
            endcase
            check_all($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
